dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data-memory port (DataMem plus the memory-mapped peripheral space behind Mmu) between the CPU load/store path (port 0) and a second bus master such as a DMA or VGA-fill engine (port 1). It grants one beat per cycle using round-robin arbitration and supports locked bursts up to a bounded length. It drives the memory-side address, data, op and strobes, and routes the one-cycle-latency read data back with a per-port valid.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared data-memory port, with bounded locked bursts.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [2:0]        op0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [2:0]        op1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [2:0]        mem_op,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnP0   = 2'd1,
        OwnP1   = 2'd2
    } own_e;

    own_e            own_q, own_d;
    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rpend_q, rpend_d;
    logic            rport_q, rport_d;

    logic            accept;
    logic            sel;
    logic            sel_we;
    logic            sel_lock;
    logic [CntW-1:0] cnt_base;
    logic [CntW-1:0] cnt_inc;

    // Grants are forced low while reset is asserted, independent of the requests.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (own_q == OwnP0 && req0 && cnt_q < CntMax) begin
                gnt0 = 1'b1;
            end else if (own_q == OwnP1 && req1 && cnt_q < CntMax) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                gnt0 = 1'b1;
`else
                if (last_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
`endif
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign accept   = gnt0 | gnt1;
    assign sel      = gnt1;
    assign sel_we   = sel ? we1 : we0;
    assign sel_lock = sel ? lock1 : lock0;

    // A beat from a non-owner starts a fresh count; the old owner has released.
    assign cnt_base = ((own_q == OwnP0 && !sel) || (own_q == OwnP1 && sel)) ? cnt_q : '0;
    assign cnt_inc  = cnt_base + 1'b1;

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_op   = 3'b000;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        if (accept) begin
            mem_addr = sel ? addr1 : addr0;
            mem_din  = sel ? wdata1 : wdata0;
            mem_op   = sel ? op1 : op0;
            mem_we   = sel_we;
            mem_re   = ~sel_we;
        end
    end

    // Without an accepted beat the owner (if any) has stopped requesting, so ownership lapses.
    always_comb begin
        own_d   = OwnNone;
        cnt_d   = '0;
        last_d  = last_q;
        rpend_d = 1'b0;
        rport_d = rport_q;
        if (accept) begin
            last_d = sel;
            if (sel_lock && cnt_inc < CntMax) begin
                own_d = sel ? OwnP1 : OwnP0;
                cnt_d = cnt_inc;
            end
            if (!sel_we) begin
                rpend_d = 1'b1;
                rport_d = sel;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            own_q   <= OwnNone;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rpend_q <= 1'b0;
            rport_q <= 1'b0;
        end else begin
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rpend_q <= rpend_d;
            rport_q <= rport_d;
        end
    end

    assign rvalid0 = rpend_q & ~rport_q;
    assign rvalid1 = rpend_q & rport_q;
    assign rdata   = mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a queue of expected read returns.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic        req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [2:0]  op0 = '0, op1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_re;
    logic [31:0] rdata, mem_addr, mem_din;
    logic [2:0]  mem_op;
    logic [31:0] mem_dout = '0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .op0(op0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_op(mem_op),
        .mem_we(mem_we), .mem_re(mem_re), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        bit          r0, w0, l0, r1, w1, l1;
        bit          e0, e1;
        logic [31:0] a0, d0, a1, d1;
        logic [2:0]  o0, o1;
    } vec_t;

    typedef struct {
        bit v;
        bit p;
    } rv_t;

    vec_t vecs[19];
    rv_t  rq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(bit rst, bit r0, bit w0, bit l0, bit r1, bit w1, bit l1,
                                bit e0, bit e1, int i);
        vec_t v;
        v.rst = rst;
        v.r0 = r0; v.w0 = w0; v.l0 = l0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1;
        v.e0 = e0; v.e1 = e1;
        v.a0 = 32'h1000 + 32'(i) * 4;
        v.d0 = 32'hA000_0000 + 32'(i);
        v.o0 = 3'(i + 1);
        v.a1 = 32'h2000 + 32'(i) * 4;
        v.d1 = 32'hB000_0000 + 32'(i);
        v.o1 = 3'(i + 5);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rvalid();
        rv_t e;
        e = '{v: 1'b0, p: 1'b0};
        if (rq.size() > 0) e = rq.pop_front();
        check("rvalid0", 32'(rvalid0), 32'(e.v && !e.p));
        check("rvalid1", 32'(rvalid1), 32'(e.v && e.p));
        if (e.v) check("rdata", rdata, mem_dout);
    endtask

    // Reset is asserted mid-cycle; outputs must drop at once even with requests held.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_gnt0", 32'(gnt0), 0);
        check("rst_gnt1", 32'(gnt1), 0);
        check("rst_rvalid", 32'({rvalid0, rvalid1}), 0);
        check("rst_strobes", 32'({mem_we, mem_re}), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_mem_op", 32'(mem_op), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rq.delete();
    endtask

    task automatic step(input vec_t v, input string tag);
        rv_t e;
        mem_dout = $urandom;
        req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0; op0 = v.o0;
        req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1; op1 = v.o1;
        #1;
        check_rvalid();
        check({tag, ".gnt0"}, 32'(gnt0), 32'(v.e0));
        check({tag, ".gnt1"}, 32'(gnt1), 32'(v.e1));
        if (v.e0) begin
            check({tag, ".we"}, 32'({mem_we, mem_re}), 32'({v.w0, !v.w0}));
            check({tag, ".addr"}, mem_addr, v.a0);
            check({tag, ".din"}, mem_din, v.d0);
            check({tag, ".op"}, 32'(mem_op), 32'(v.o0));
        end else if (v.e1) begin
            check({tag, ".we"}, 32'({mem_we, mem_re}), 32'({v.w1, !v.w1}));
            check({tag, ".addr"}, mem_addr, v.a1);
            check({tag, ".din"}, mem_din, v.d1);
            check({tag, ".op"}, 32'(mem_op), 32'(v.o1));
        end else begin
            check({tag, ".we"}, 32'({mem_we, mem_re}), 0);
            check({tag, ".addr"}, mem_addr, 0);
        end
        e.v = (v.e0 && !v.w0) || (v.e1 && !v.w1);
        e.p = v.e1;
        rq.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
        // rst r0 w0 l0 r1 w1 l1 e0 e1
        vecs[0] = mk(1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        vecs[0].a0 = 32'h100; vecs[0].d0 = 32'hDEAD_BEEF; vecs[0].o0 = 3'b010;
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[2] = mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 2);
        vecs[3] = mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 3);
        vecs[4] = mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 4);
        vecs[5] = mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 5);
        vecs[6] = mk(0, 1, 0, 0, 1, 1, 1, 1, 0, 6);
        for (int i = 7; i < 15; i++) vecs[i] = mk(0, 1, 0, 0, 1, 1, 1, 0, 1, i);
        vecs[15] = mk(0, 1, 0, 0, 1, 1, 1, 1, 0, 15);
        for (int i = 16; i < 19; i++) vecs[i] = mk(0, 1, 0, 0, 1, 0, 1, 0, 1, i);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Port 1 owns with cnt=3, then drops req1 while port 0 is waiting.
        check("own_before_drop", 32'(dut.own_q), 2);
        check("cnt_before_drop", 32'(dut.cnt_q), 3);
        step(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 20), "drop");
        check("own_after_drop", 32'(dut.own_q), 0);
        check("cnt_after_drop", 32'(dut.cnt_q), 0);

        // Port 1 read burst interrupted by reset.
        step(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 21), "burst_a");
        step(mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 22), "burst_b");
        check_rvalid();
        do_reset();
        step(mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 23), "post_rst_tie");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 24), "post_rst_idle");
`else
        do_reset();
        for (int i = 0; i < 5; i++) step(mk(0, 1, 0, 0, 1, 0, 0, 1, 0, i), $sformatf("fix%0d", i));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5), "fix_idle");
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
